// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter: byte queue, 11-bit frame serializer, inter-frame gap
// Define PS2_DEVICE_TX_FIFO_EN for a FIFO_DEPTH-entry byte FIFO; otherwise a single holding register.
module ps2_device_tx #(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_HALVES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
  localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, LOW, GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [10:0]   r_shift;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [7:0]  w_head;
  logic [10:0] w_frame;

  assign w_push  = valid && ready;
  // A queued byte is taken straight from the gap so back-to-back frames see exactly the gap time idle.
  assign w_pop   = !w_empty && ((r_state == IDLE) || (r_state == GAP && r_cnt == '0));
  assign w_frame = {1'b1, ~^w_head, w_head, 1'b0};

`ifdef PS2_DEVICE_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign ready   = (r_count != (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_hold_full;

  assign ready   = !busy && !r_hold_full;
  assign w_empty = !r_hold_full;
  assign w_head  = r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_push) begin
      r_hold      <= data_in;
      r_hold_full <= 1'b1;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= SETUP;
            r_shift  <= w_frame;
            r_idx    <= '0;
            r_cnt    <= HALF_LOAD;
            ps2_data <= w_frame[0];
            ps2_clk  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state <= LOW;
            ps2_clk <= 1'b0;
            r_cnt   <= HALF_LOAD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        LOW: begin
          if (r_cnt == '0) begin
            ps2_clk <= 1'b1;
            if (r_idx == 4'd10) begin
              r_state  <= GAP;
              ps2_data <= 1'b1;
              r_cnt    <= GAP_LOAD;
            end else begin
              r_state  <= SETUP;
              r_idx    <= r_idx + 4'd1;
              r_shift  <= {1'b1, r_shift[10:1]};
              ps2_data <= r_shift[1];
              r_cnt    <= HALF_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            if (w_pop) begin
              r_state  <= SETUP;
              r_shift  <= w_frame;
              r_idx    <= '0;
              r_cnt    <= HALF_LOAD;
              ps2_data <= w_frame[0];
              ps2_clk  <= 1'b1;
              busy     <= 1'b1;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - scoreboard bench for ps2_device_tx (CLK_DIV=4, GAP_HALVES=4, FIFO_DEPTH=8)
module tb_ps2_device_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  ps2_device_tx #(.CLK_DIV(4), .FIFO_DEPTH(8), .GAP_HALVES(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
    .ready(ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_q[$];

  int          m_nbits = 0, m_falls = 0, m_frames = 0, m_first_fall = 0;
  int          m_hi_run = 0, m_last_gap = 0, m_busy_run = 0, m_last_busy = 0;
  logic [10:0] m_bits = '0, m_last_bits = '0;
  logic        m_prev_clk = 1'b1, m_prev_data = 1'b1;
  logic [7:0]  m_exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: samples ps2_data on each ps2_clk fall and scores complete frames.
  always @(negedge clk) begin
    if (reset) begin
      m_nbits = 0; m_prev_clk = 1'b1; m_prev_data = 1'b1; m_hi_run = 0; m_busy_run = 0;
    end else begin
      if (ps2_clk && !ps2_data && m_prev_clk && m_prev_data && m_nbits == 0) begin
        start_q.push_back(cyc);
        m_last_gap = m_hi_run;
      end
      if (m_prev_clk && !ps2_clk) begin
        if (m_nbits == 0) m_first_fall = cyc;
        m_bits[m_nbits] = ps2_data;
        m_nbits++;
        m_falls++;
        if (m_nbits == 11) begin
          m_nbits = 0;
          m_frames++;
          m_last_bits = m_bits;
          chk("sb_start_bit", m_bits[0], 0);
          chk("sb_stop_bit", m_bits[10], 1);
          chk("sb_parity_odd", ^m_bits[9:1], 1);
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_unexpected_frame: got 0x%02h, required no frame", m_bits[8:1]);
          end else begin
            m_exp_b = exp_q.pop_front();
            chk("sb_data", m_bits[8:1], m_exp_b);
          end
        end
      end
      m_hi_run = (ps2_clk && ps2_data) ? m_hi_run + 1 : 0;
      if (busy) m_busy_run++;
      else begin
        if (m_busy_run != 0) m_last_busy = m_busy_run;
        m_busy_run = 0;
      end
      m_prev_clk = ps2_clk;
      m_prev_data = ps2_data;
    end
  end

  task automatic push(input logic [7:0] b, output int acc);
    int n;
    n = 0;
    data_in = b;
    valid = 1'b1;
    while (!ready && n < 400) begin @(negedge clk); n++; end
    chk("push_wait_ready", (n < 400), 1);
    exp_q.push_back(b);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || m_nbits != 0) && n < 3000) begin @(negedge clk); n++; end
    chk(name, (n < 3000), 1);
    @(negedge clk);
  endtask

  int a1, a2, f0, fb, frb, n_exp_frames;
  logic [7:0] b1, b2;
  int exp_delta, exp_gap;

  initial begin
    n_exp_frames = 0;
    repeat (3) @(negedge clk);
    chk("reset_ps2_clk", ps2_clk, 1);
    chk("reset_ps2_data", ps2_data, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", ready, 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    f0 = m_falls;
    push(8'h1C, a1);
    wait_idle("idle_after_1C");
    n_exp_frames++;
    chk("latency_first_fall", m_first_fall - a1, 5);
    chk("bits_1C", m_last_bits, 11'b10000111000);
    chk("busy_len_1C", m_last_busy, 104);
    chk("falls_1C", m_falls - f0, 11);

    push(8'h00, a1);
    wait_idle("idle_after_00");
    n_exp_frames++;
    chk("parity_00", m_last_bits[9], 1);
    push(8'hFF, a1);
    wait_idle("idle_after_FF");
    n_exp_frames++;
    chk("parity_FF", m_last_bits[9], 1);

`ifdef PS2_DEVICE_TX_FIFO_EN
    b1 = 8'hF0; b2 = 8'h1C; exp_delta = 1; exp_gap = 16;
`else
    b1 = 8'h1C; b2 = 8'h32; exp_delta = 106; exp_gap = 18;
`endif
    push(b1, a1);
`ifndef PS2_DEVICE_TX_FIFO_EN
    chk("hold_ready_low", ready, 0);
`endif
    push(b2, a2);
    wait_idle("idle_after_b2b");
    n_exp_frames += 2;
    chk("b2b_accept_delta", a2 - a1, exp_delta);
    chk("b2b_gap_cycles", m_last_gap, exp_gap);

`ifdef PS2_DEVICE_TX_FIFO_EN
    begin
      logic [7:0] burst [10];
      int acc_n, n;
      burst = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h3C, 8'hC3};
      start_q.delete();
      acc_n = 0;
      valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
        data_in = burst[acc_n];
        if (k == 9) chk("burst_ready_cycle10", ready, 0);
        if (ready) begin exp_q.push_back(burst[acc_n]); acc_n++; end
        @(negedge clk);
      end
      chk("burst_accepted_9", acc_n, 9);
      data_in = burst[9];
      n = 0;
      while (!ready && n < 400) begin @(negedge clk); n++; end
      chk("burst_10th_wait", (n < 400), 1);
      exp_q.push_back(burst[9]);
      @(posedge clk);
      @(negedge clk);
      a2 = cyc;
      valid = 1'b0;
      chk("burst_frame2_started", (start_q.size() >= 2), 1);
      if (start_q.size() >= 2) chk("burst_10th_after_pop", a2 - start_q[1], 1);
      wait_idle("idle_after_burst");
      n_exp_frames += 10;
    end
`endif

    push(8'hA5, a1);
`ifdef PS2_DEVICE_TX_FIFO_EN
    push(8'h77, a1);
`endif
    begin
      int n;
      n = 0;
      while (m_nbits != 5 && n < 500) begin @(negedge clk); n++; end
      chk("reach_bit5", (n < 500), 1);
    end
    reset = 1'b1;
    #1;
    chk("abort_ps2_clk", ps2_clk, 1);
    chk("abort_ps2_data", ps2_data, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 1);
    exp_q.delete();
    fb = m_falls;
    frb = m_frames;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_edges_after_abort", m_falls, fb);
    chk("no_frame_after_abort", m_frames, frb);
    chk("idle_after_abort", busy, 0);

    push(8'h5A, a1);
    wait_idle("idle_after_5A");
    n_exp_frames++;
    chk("post_reset_latency", m_first_fall - a1, 5);

    chk("frame_count", m_frames, n_exp_frames);
    chk("total_falls", m_falls, 11 * n_exp_frames + 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 50, clk cycles per ps2_clk half-period (min 2).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 8, byte FIFO entries (power of 2, min 2).
REQ-003 SHALL provide parameter GAP_HALVES, default 4, idle half-periods inserted after each stop bit (min 1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  8  scan-code byte to transmit.
REQ-007 valid  input  1  data_in is valid; a byte transfers on a rising edge where valid && ready.
REQ-008 ready  output  1  the block can accept a byte this cycle.
REQ-009 ps2_clk  output  1  PS/2 clock, idle high.
REQ-010 ps2_data  output  1  PS/2 data, idle high.
REQ-011 busy  output  1  a frame or its trailing gap is in progress.

Function
REQ-012 Frame SHALL be 11 bits: start 0, data[0..7] LSB first, odd parity (~^byte), stop 1.
REQ-013 FSM states SHALL be IDLE, SETUP, LOW, GAP; all outputs registered.
REQ-014 IDLE: ps2_clk=1, ps2_data=1, busy=0; if the FIFO is non-empty, pop the head, load the 11-bit frame, bit index 0, enter SETUP.
REQ-015 SETUP: lasts CLK_DIV cycles; ps2_clk=1, ps2_data=current bit; ps2_data changes only on entry to SETUP.
REQ-016 LOW: lasts CLK_DIV cycles; ps2_clk=0, ps2_data held; on exit, index<10 -> index+1 and SETUP, index==10 -> GAP.
REQ-017 GAP: lasts GAP_HALVES*CLK_DIV cycles, ps2_clk=1, ps2_data=1, then IDLE.
REQ-018 Latency: byte accepted at edge N into an empty FIFO with the FSM in IDLE -> ps2_data=0 after edge N+1, first ps2_clk fall after edge N+1+CLK_DIV.
REQ-019 A frame SHALL occupy exactly 22*CLK_DIV cycles from SETUP entry to GAP entry, with exactly 11 ps2_clk falling edges.
REQ-020 ready SHALL equal !full; a byte offered while full is not accepted and no data is lost or overwritten.
REQ-021 A push and a pop in the same cycle SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 busy SHALL be 1 in SETUP, LOW and GAP.
REQ-023 valid while ready=0 SHALL have no effect; data_in SHALL be sampled only on an accepted transfer.

Reset
REQ-024 reset SHALL immediately force IDLE, ps2_clk=1, ps2_data=1, busy=0, and clear the FIFO; ready=1 after reset.
REQ-025 reset mid-frame SHALL abort the frame with no further ps2_clk edges; after release, no partial frame is resumed.

Configuration
REQ-026 With macro PS2_DEVICE_TX_FIFO_EN defined, the FIFO_DEPTH-entry FIFO SHALL be built as above.
REQ-027 Without PS2_DEVICE_TX_FIFO_EN, storage SHALL be a single holding register, ready = !busy && !holding_full; FIFO_DEPTH is ignored.

Verification (CLK_DIV=4, GAP_HALVES=4, FIFO_DEPTH=8)
REQ-028 Push 0x1C -> ps2_data at the 11 ps2_clk falls = 0,0,0,1,1,1,0,0,0,0,1; first fall 5 cycles after acceptance; busy for 88+16 cycles.
REQ-029 Push 0x00 -> parity bit 1; push 0xFF -> parity bit 1; a receiver model sampling on ps2_clk falls decodes both with valid start, stop and parity.
REQ-030 Push 0xF0, 0x1C back to back -> two frames, exactly 16 cycles of ps2_clk=ps2_data=1 between the last fall of frame 1 plus its LOW half and the start bit of frame 2.
REQ-031 With the FIFO enabled, assert valid for 10 consecutive cycles from idle -> 9 bytes accepted, ready low from the 10th cycle, the 10th byte accepted one cycle after frame 1's pop frees a slot, 10 frames emitted in order.
REQ-032 Assert reset during bit 5 of a frame -> ps2_clk=1 and ps2_data=1 in the same cycle, no further edges, FIFO empty; the next push transmits normally.
REQ-033 Without PS2_DEVICE_TX_FIFO_EN, push 0x1C then 0x32 -> ready low from acceptance until the holding register empties; 0x32 frame follows the 0x1C frame's gap.
